// File: rtl/list_stream_pkg.sv
// list_stream_pkg
//   Shared definitions for the list-stream prefetch slice.
//   - LIST_DATA_W   : default element width
//   - fetch_state_t : upstream fetch FSM states
//   - occ_w()       : width needed to hold an occupancy of 0..depth
package list_stream_pkg;

  localparam int unsigned LIST_DATA_W = 8;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_GAP,
    F_END
  } fetch_state_t;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/list_prefetch_fifo.sv
// list_prefetch_fifo
//   Plain synchronous FIFO used as the prefetch store. Knows nothing about the
//   list protocol; the owner guarantees no push when full and no pop when empty.
//   Push and pop in the same cycle are allowed and leave the count unchanged.
// Ports
//   i_clk         clock, all logic on posedge
//   i_rst_n       synchronous active-low reset
//   i_push        write i_push_data at the tail
//   i_push_data   element to write
//   i_pop         drop the head element
//   o_head        current head element (valid when !o_empty)
//   o_full        count == DEPTH
//   o_empty       count == 0
//   o_count_next  occupancy after this cycle (only with LIST_PREFETCH_STATS_EN)
// Configuration macro: LIST_PREFETCH_STATS_EN
module list_prefetch_fifo
  import list_stream_pkg::*;
#(
  parameter int unsigned DATA_W = LIST_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
`ifdef LIST_PREFETCH_STATS_EN
  ,
  output logic [occ_w(DEPTH)-1:0] o_count_next
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = occ_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;

  always_comb begin
    w_count_next = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

`ifdef LIST_PREFETCH_STATS_EN
  assign o_count_next = w_count_next;
`endif

endmodule

// File: rtl/list_prefetch_buffer.sv
// list_prefetch_buffer
//   Pulls list elements from an upstream producer ahead of demand, holds up to
//   DEPTH of them, and re-serves them downstream over the same req/ack list
//   protocol, so a consumer hitting the buffer is answered in one cycle.
// Ports
//   clock            clock, all logic on posedge
//   ready            synchronous active-low reset (0 = reset, 1 = run)
//   src_req          upstream request, held until src_ack
//   src_ack          upstream ack pulse
//   src_value        upstream element, sampled with src_ack
//   src_value_valid  0 together with src_ack marks upstream end-of-list
//   req              downstream request; each rising edge is one request
//   ack              one-cycle ack pulse per served request
//   value            served element, held until the next ack
//   value_valid      1 = element, 0 = end-of-list
//   max_occ          FIFO high-water mark (only with LIST_PREFETCH_STATS_EN)
// Configuration macro: LIST_PREFETCH_STATS_EN
module list_prefetch_buffer
  import list_stream_pkg::*;
#(
  parameter int unsigned DATA_W = LIST_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              ready,
  output logic              src_req,
  input  logic              src_ack,
  input  logic [DATA_W-1:0] src_value,
  input  logic              src_value_valid,
  input  logic              req,
  output logic              ack,
  output logic [DATA_W-1:0] value,
  output logic              value_valid
`ifdef LIST_PREFETCH_STATS_EN
  ,
  output logic [occ_w(DEPTH)-1:0] max_occ
`endif
);

  localparam int unsigned CW = occ_w(DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic              w_src_req;
  logic              w_push;
  logic              w_set_eol;

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  logic              r_eol;
  logic              r_pending;
  logic              r_last_req;
  logic              r_ack;
  logic [DATA_W-1:0] r_value;
  logic              r_value_valid;

  logic              w_edge;
  logic              w_accept;
  logic              w_service;
  logic              w_pop;
  logic              w_eol_ack;
  logic              w_set_pending;

`ifdef LIST_PREFETCH_STATS_EN
  logic [CW-1:0]     w_count_next;
  logic [CW-1:0]     r_max_occ;
`endif

  list_prefetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk        (clock),
    .i_rst_n      (ready),
    .i_push       (w_push),
    .i_push_data  (src_value),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
`ifdef LIST_PREFETCH_STATS_EN
    ,
    .o_count_next (w_count_next)
`endif
  );

  // Upstream fetch FSM: at most one request in flight. Fullness is checked
  // only at issue time; pops can only lower the count, so the push cannot
  // overflow.
  always_ff @(posedge clock) begin
    if (!ready) begin
      r_state <= F_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_src_req    = 1'b0;
    w_push       = 1'b0;
    w_set_eol    = 1'b0;
    case (r_state)
      F_IDLE: begin
        if (!r_eol && !w_full) begin
          w_state_next = F_REQ;
        end
      end
      F_REQ: begin
        w_src_req = 1'b1;
        if (src_ack) begin
          if (src_value_valid) begin
            w_push       = 1'b1;
            w_state_next = F_GAP;
          end else begin
            w_set_eol    = 1'b1;
            w_state_next = F_END;
          end
        end
      end
      // One low cycle so the producer sees a fresh request edge.
      F_GAP:   w_state_next = F_IDLE;
      F_END:   w_state_next = F_END;
      default: w_state_next = F_IDLE;
    endcase
  end

  assign src_req = w_src_req;

  // Downstream side. A pending request is retried every cycle until either an
  // element is in the FIFO or end-of-list is known; new edges are ignored
  // while one is pending or while the ack pulse is still high.
  assign w_edge        = req & ~r_last_req;
  assign w_accept      = w_edge & ~r_pending & ~r_ack;
  assign w_service     = w_accept | r_pending;
  assign w_pop         = w_service & ~w_empty;
  assign w_eol_ack     = w_service & w_empty & r_eol;
  assign w_set_pending = w_accept & w_empty & ~r_eol;

  always_ff @(posedge clock) begin
    if (!ready) begin
      r_eol         <= 1'b0;
      r_pending     <= 1'b0;
      r_last_req    <= 1'b0;
      r_ack         <= 1'b0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
    end else begin
      r_last_req <= req;
      r_ack      <= w_pop | w_eol_ack;
      if (w_set_eol) begin
        r_eol <= 1'b1;
      end
      if (w_pop || w_eol_ack) begin
        r_pending <= 1'b0;
      end else if (w_set_pending) begin
        r_pending <= 1'b1;
      end
      if (w_pop) begin
        r_value       <= w_head;
        r_value_valid <= 1'b1;
      end else if (w_eol_ack) begin
        r_value       <= '0;
        r_value_valid <= 1'b0;
      end
    end
  end

  assign ack         = r_ack;
  assign value       = r_value;
  assign value_valid = r_value_valid;

`ifdef LIST_PREFETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (!ready) begin
      r_max_occ <= '0;
    end else if (w_count_next > r_max_occ) begin
      r_max_occ <= w_count_next;
    end
  end

  assign max_occ = r_max_occ;
`endif

endmodule

// File: tb/tb_list_prefetch_buffer.sv
// tb_list_prefetch_buffer
//   Bench for list_prefetch_buffer (DATA_W=8, DEPTH=4). The producer is a
//   BoundedEnum list (-2, 1, 4, 7, then end-of-list). The reference rule is
//   that the k-th served request returns list element k, or end-of-list once
//   the list is exhausted; a request finding buffered data (or known
//   end-of-list) is answered one cycle after its edge.
// Configuration macro: LIST_PREFETCH_STATS_EN
module tb_list_prefetch_buffer;

  logic       clock;
  logic       ready;
  logic       src_req;
  logic       src_ack;
  logic [7:0] src_value;
  logic       src_value_valid;
  logic       req;
  logic       ack;
  logic [7:0] value;
  logic       value_valid;
`ifdef LIST_PREFETCH_STATS_EN
  logic [2:0] max_occ;
`endif

  list_prefetch_buffer #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clock           (clock),
    .ready           (ready),
    .src_req         (src_req),
    .src_ack         (src_ack),
    .src_value       (src_value),
    .src_value_valid (src_value_valid),
    .req             (req),
    .ack             (ack),
    .value           (value),
    .value_valid     (value_valid)
`ifdef LIST_PREFETCH_STATS_EN
    ,
    .max_occ         (max_occ)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned n_push   = 0;
  int unsigned n_pop    = 0;
  bit          eol_seen = 0;
  int unsigned up_idx   = 0;
  int unsigned up_wait  = 0;
  int unsigned up_lat   = 0;
  bit          rand_lat = 0;

  localparam int unsigned LIST_LEN = 4;

  // BoundedEnum min=-2 step=3 max=7
  function automatic logic [7:0] elem(input int unsigned i);
    int v;
    v = -2 + 3 * int'(i);
    return 8'(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: note what the coming edge does, then advance the producer model.
  task automatic cyc();
    logic rdy, acc, pv;
    rdy = ready;
    acc = src_req && src_ack;
    pv  = src_value_valid;
    @(posedge clock);
    #1;
    if (!rdy) begin
      up_idx = 0; up_wait = 0;
      src_ack = 0; src_value_valid = 0; src_value = '0;
    end else if (acc) begin
      if (pv) begin
        n_push++;
        up_idx++;
      end else begin
        eol_seen = 1;
      end
      src_ack = 0; src_value_valid = 0; src_value = '0; up_wait = 0;
      if (rand_lat) up_lat = $urandom_range(0, 3);
    end else if (src_req && !src_ack) begin
      if (up_wait >= up_lat) begin
        src_ack         = 1;
        src_value_valid = (up_idx < LIST_LEN);
        src_value       = (up_idx < LIST_LEN) ? elem(up_idx) : 8'h00;
      end else begin
        up_wait++;
      end
    end
  endtask

  task automatic clear_model();
    n_push = 0; n_pop = 0; eol_seen = 0;
  endtask

  task automatic reset_dut();
    ready = 0; req = 0;
    cyc(); cyc();
    clear_model();
    ready = 1;
  endtask

  task automatic do_req(input string nm, input logic exp_v, input logic [7:0] exp_val);
    bit hit;
    int unsigned waited;
    hit = (n_push > n_pop) || eol_seen;
    req = 1;
    cyc();
    waited = 1;
    while (ack !== 1'b1 && waited < 60) begin
      cyc();
      waited++;
    end
    check({nm, ".ack"}, 32'(ack), 32'd1);
    if (hit) check({nm, ".lat"}, waited, 32'd1);
    else     check({nm, ".lat_min2"}, 32'(waited >= 2), 32'd1);
    check({nm, ".valid"}, 32'(value_valid), 32'(exp_v));
    check({nm, ".value"}, 32'(value), 32'(exp_val));
    if (exp_v) n_pop++;
    req = 0;
    cyc();
    check({nm, ".ack_pulse"}, 32'(ack), 32'd0);
  endtask

  typedef struct {
    int unsigned gap;
    logic        exp_v;
    logic [7:0]  exp_val;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int unsigned w;

    tbl[0] = '{gap: 1, exp_v: 1'b1, exp_val: 8'hFE};
    tbl[1] = '{gap: 0, exp_v: 1'b1, exp_val: 8'h01};
    tbl[2] = '{gap: 2, exp_v: 1'b1, exp_val: 8'h04};
    tbl[3] = '{gap: 0, exp_v: 1'b1, exp_val: 8'h07};
    tbl[4] = '{gap: 1, exp_v: 1'b0, exp_val: 8'h00};
    tbl[5] = '{gap: 3, exp_v: 1'b0, exp_val: 8'h00};

    ready = 0; req = 0; src_ack = 0; src_value = '0; src_value_valid = 0;

    // Reset state
    reset_dut();
    check("rst.src_req", 32'(src_req), 32'd0);
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.value", 32'(value), 32'd0);
    check("rst.valid", 32'(value_valid), 32'd0);
`ifdef LIST_PREFETCH_STATS_EN
    check("rst.max_occ", 32'(max_occ), 32'd0);
`endif

    // Test 1: fill with no downstream demand
    w = 0;
    while (n_push < 4 && w < 60) begin cyc(); w++; end
    check("t1.pushes", n_push, 32'd4);
    for (int i = 0; i < 8; i++) begin
      check("t1.src_req_full", 32'(src_req), 32'd0);
      cyc();
    end
    check("t1.no_extra_push", n_push, 32'd4);
`ifdef LIST_PREFETCH_STATS_EN
    check("t1.max_occ", 32'(max_occ), 32'd4);
`endif

    // Tests 2-3: drain then end-of-list
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < int'(tbl[i].gap); g++) begin
        check("t23.gap_ack", 32'(ack), 32'd0);
        cyc();
      end
      do_req($sformatf("t23[%0d]", i), tbl[i].exp_v, tbl[i].exp_val);
    end
    for (int i = 0; i < 5; i++) begin
      check("t3.src_req_end", 32'(src_req), 32'd0);
      cyc();
    end

    // Test 4: request right after reset, FIFO empty
    reset_dut();
`ifdef LIST_PREFETCH_STATS_EN
    check("t4.max_occ_rst", 32'(max_occ), 32'd0);
`endif
    cyc();
    check("t4.src_req", 32'(src_req), 32'd1);
    req = 1;
    cyc();
    check("t4.pend_ack", 32'(ack), 32'd0);
    check("t4.push1", n_push, 32'd1);
    cyc();
    check("t4.ack", 32'(ack), 32'd1);
    check("t4.value", 32'(value), 32'h000000FE);
    check("t4.valid", 32'(value_valid), 32'd1);
    n_pop++;
    req = 0;
    cyc();
    check("t4.ack_pulse", 32'(ack), 32'd0);

    // Test 5: pop edge coinciding with a push at count=2
    w = 0;
    while (!(n_push == 3 && src_req && src_ack && src_value_valid) && w < 40) begin
      cyc(); w++;
    end
    check("t5.setup", 32'(n_push == 3 && src_req && src_ack && src_value_valid), 32'd1);
    do_req("t5.a", 1'b1, 8'h01);
    do_req("t5.b", 1'b1, 8'h04);
    do_req("t5.c", 1'b1, 8'h07);

    // Test 6: reset while fetching with a request pending
    up_lat = 3;
    reset_dut();
    cyc();
    check("t6.src_req", 32'(src_req), 32'd1);
    req = 1;
    cyc();
    check("t6.pend_ack", 32'(ack), 32'd0);
    check("t6.still_req", 32'(src_req), 32'd1);
    ready = 0; req = 0;
    cyc();
    check("t6.rst_src_req", 32'(src_req), 32'd0);
    check("t6.rst_ack", 32'(ack), 32'd0);
    check("t6.rst_value", 32'(value), 32'd0);
    check("t6.rst_valid", 32'(value_valid), 32'd0);
`ifdef LIST_PREFETCH_STATS_EN
    check("t6.max_occ", 32'(max_occ), 32'd0);
`endif
    cyc();
    clear_model();
    up_lat = 0;
    ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t6.no_stale_ack", 32'(ack), 32'd0);
    end
    do_req("t6.restart", 1'b1, 8'hFE);

    // Randomised episodes against the list reference
    rand_lat = 1;
    for (int ep = 0; ep < 8; ep++) begin
      up_lat = $urandom_range(0, 3);
      reset_dut();
      for (int k = 0; k < 7; k++) begin
        int unsigned gap;
        gap = $urandom_range(0, 5);
        for (int g = 0; g < int'(gap); g++) begin
          cyc();
          check("rnd.gap_ack", 32'(ack), 32'd0);
        end
        if (k < int'(LIST_LEN))
          do_req($sformatf("rnd[%0d.%0d]", ep, k), 1'b1, elem(k));
        else
          do_req($sformatf("rnd[%0d.%0d]", ep, k), 1'b0, 8'h00);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
